// File: rtl/insn_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the program counter, drives the
// combinational instruction memory and buffers fetched words with their PCs
// in a small prefetch FIFO that feeds decode over a valid/ready handshake.
// Also handles start/stop, redirect with flush, and fetch faults.
module insn_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_insn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;

  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] insn_mem  [FIFO_DEPTH];
  logic        fault_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] fetch_count_q;

  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        fetch_fire;
  logic        pc_fault;
  logic [31:0] push_insn;

  // Handshake and fetch qualification; a redirect suppresses both pop and push
  // because the whole FIFO is being thrown away that cycle.
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    pop        = !fifo_empty && out_ready && !redirect_valid;
    fetch_fire = (state == RUN) && !redirect_valid && (!fifo_full || pop);
    pc_fault   = (pc[1:0] != 2'b00) || (pc >= ADDR_LIMIT);
    push_insn  = pc_fault ? 32'h0 : imem_insn;
  end

  // Next-state and next-pc selection; redirect wins over everything but reset.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (state == HALT) begin
        state_next = RUN;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (fetch_fire && pc_fault) begin
            state_next = HALT;
          end else if (!en) begin
            state_next = IDLE;
          end
          if (fetch_fire && !pc_fault) begin
            pc_next = pc + 32'd4;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and program counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (fetch_fire && !pop) begin
        count <= count + CNT_ONE;
      end else if (!fetch_fire && pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // FIFO entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      pc_mem[wr_ptr]    <= pc;
      insn_mem[wr_ptr]  <= push_insn;
      fault_mem[wr_ptr] <= pc_fault;
    end
  end

  // Running count of pushed entries, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'h0;
    end else if (fetch_fire) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign imem_addr   = pc;
  assign out_valid   = !fifo_empty;
  assign out_pc      = out_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign out_insn    = out_valid ? insn_mem[rd_ptr]  : 32'h0;
  assign out_fault   = out_valid ? fault_mem[rd_ptr] : 1'b0;
  assign halted      = (state == HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Self-checking bench for insn_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared each cycle against a queue-based model.
module tb_insn_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] ADDR_LIMIT = 32'h0000_1000;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_insn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        halted;
  logic [31:0] fetch_count;

  int errors;
  int checks;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_cnt;

  insn_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_LIMIT(ADDR_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .imem_addr     (imem_addr),
    .imem_insn     (imem_insn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_insn      (out_insn),
    .out_pc        (out_pc),
    .out_fault     (out_fault),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  // Instruction memory: word k holds k + 0x100.
  assign imem_insn = (imem_addr >> 2) + 32'h100;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one clock edge of the fetch unit described in terms of
  // a queue of {pc, insn, fault} records.
  task automatic modelStep(input logic a_en, input logic a_rv, input logic [31:0] a_rpc,
                           input logic a_ready, input logic a_rst);
    bit     do_pop;
    bit     do_fetch;
    bit     is_fault;
    entry_t e;
    if (a_rst) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_mode = M_IDLE;
      m_cnt  = 32'h0;
    end else if (a_rv) begin
      m_q.delete();
      m_pc = a_rpc;
      if (m_mode == M_HALT) m_mode = M_RUN;
    end else begin
      do_pop   = (m_q.size() > 0) && a_ready;
      do_fetch = (m_mode == M_RUN) && ((m_q.size() < FIFO_DEPTH) || do_pop);
      is_fault = 0;
      if (do_pop) void'(m_q.pop_front());
      if (do_fetch) begin
        is_fault = (m_pc % 4 != 0) || (m_pc >= ADDR_LIMIT);
        e.pc    = m_pc;
        e.insn  = is_fault ? 32'h0 : (m_pc / 4) + 32'h100;
        e.fault = is_fault;
        m_q.push_back(e);
        m_cnt = m_cnt + 32'd1;
        if (!is_fault) m_pc = m_pc + 32'd4;
      end
      if (do_fetch && is_fault) m_mode = M_HALT;
      else if (m_mode == M_IDLE && a_en) m_mode = M_RUN;
      else if (m_mode == M_RUN && !a_en) m_mode = M_IDLE;
    end
  endtask

  task automatic compareAll();
    logic [31:0] e_pc;
    logic [31:0] e_insn;
    logic        e_fault;
    e_pc = 32'h0; e_insn = 32'h0; e_fault = 1'b0;
    if (m_q.size() > 0) begin
      e_pc    = m_q[0].pc;
      e_insn  = m_q[0].insn;
      e_fault = m_q[0].fault;
    end
    checkOutput("out_valid",   {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    checkOutput("out_pc",      out_pc, e_pc);
    checkOutput("out_insn",    out_insn, e_insn);
    checkOutput("out_fault",   {31'b0, out_fault}, {31'b0, e_fault});
    checkOutput("halted",      {31'b0, halted}, {31'b0, m_mode == M_HALT});
    checkOutput("imem_addr",   imem_addr, m_pc);
    checkOutput("fetch_count", fetch_count, m_cnt);
  endtask

  // Drive one cycle of inputs, advance the model, and check after the edge.
  task automatic applyStimulus(input logic a_en, input logic a_rv, input logic [31:0] a_rpc,
                               input logic a_ready, input logic a_rst);
    en             = a_en;
    redirect_valid = a_rv;
    redirect_pc    = a_rpc;
    out_ready      = a_ready;
    rst            = a_rst;
    modelStep(a_en, a_rv, a_rpc, a_ready, a_rst);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        r_en;
    logic        r_rv;
    logic        r_ready;
    logic        r_rst;
    int          sel;
    logic [31:0] cnt_snap;

    errors = 0;
    checks = 0;
    clk = 1'b0; rst = 1'b1; en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;
    m_q.delete(); m_pc = RESET_PC; m_mode = M_IDLE; m_cnt = 32'h0;

    // Streaming from reset: first delivery two cycles after release.
    doReset();
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("lat_c1_valid", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("lat_c2_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("lat_c2_insn", out_insn, 32'h100);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_pc", out_pc, 32'h20);

    // Stall: FIFO fills and pc holds.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_count", fetch_count, 32'd4);
    checkOutput("stall_addr", imem_addr, 32'h10);
    checkOutput("stall_head", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Redirect with three entries queued.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_redir_count", fetch_count, 32'd3);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
    checkOutput("redir_flush", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("redir_first", out_pc, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("redir_second", out_pc, 32'h44);

    // Misaligned redirect target faults and halts; a redirect recovers.
    applyStimulus(1'b1, 1'b1, 32'h42, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("mis_pc", out_pc, 32'h42);
    checkOutput("mis_fault", {31'b0, out_fault}, 32'h1);
    checkOutput("mis_insn", out_insn, 32'h0);
    checkOutput("mis_halted", {31'b0, halted}, 32'h1);
    cnt_snap = fetch_count;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt_no_push", fetch_count, cnt_snap);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 1'b0);
    checkOutput("unhalt", {31'b0, halted}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("resume_pc", out_pc, 32'h80);

    // Run up to the address limit.
    applyStimulus(1'b1, 1'b1, 32'hFF0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("last_ok_pc", out_pc, 32'hFFC);
    checkOutput("last_ok_fault", {31'b0, out_fault}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("limit_pc", out_pc, 32'h1000);
    checkOutput("limit_fault", {31'b0, out_fault}, 32'h1);
    checkOutput("limit_halted", {31'b0, halted}, 32'h1);

    // Full FIFO while halted, then reset mid-stream.
    applyStimulus(1'b1, 1'b1, 32'hFF4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("full_halted", {31'b0, halted}, 32'h1);
    checkOutput("full_head", out_pc, 32'hFF4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("mid_rst_halted", {31'b0, halted}, 32'h0);
    checkOutput("mid_rst_addr", imem_addr, RESET_PC);
    checkOutput("mid_rst_count", fetch_count, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r_en    = ($urandom_range(0, 7) != 0);
      r_ready = ($urandom_range(0, 3) != 0);
      r_rv    = ($urandom_range(0, 15) == 0);
      r_rst   = ($urandom_range(0, 299) == 0);
      sel     = $urandom_range(0, 9);
      if (sel < 6)      rpc = {20'h0, $urandom_range(0, 1023) % 1024 == 0 ? 10'h0 : 10'($urandom_range(0, 1023)), 2'b00};
      else if (sel < 8) rpc = 32'hFE0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      else if (sel < 9) rpc = {20'h0, 12'($urandom_range(0, 4095))} | 32'h1;
      else              rpc = $urandom;
      applyStimulus(r_en, r_rv, rpc, r_ready, r_rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
